// File: rtl/pc_pkg.sv
// Shared definitions for the sequencer program counter: default width,
// the PC value type and the reset value.
package pc_pkg;

  localparam int unsigned PC_WIDTH = 9;

  typedef logic [PC_WIDTH-1:0] pc_t;

  localparam int unsigned PC_RESET = 0;

endpackage

// File: rtl/pc_counter.sv
// Program counter for the snooping-cache test sequencer: sync reset, parallel
// load, wrapping increment and a terminal-count flag decoded from the register.
module pc_counter
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH       = PC_WIDTH,
  parameter int unsigned RESET_VALUE = PC_RESET,
  parameter int unsigned MAX_VALUE   = (2 ** WIDTH) - 1,
  parameter int unsigned STEP        = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             PcEnable,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic [WIDTH-1:0] PC,
  output logic             TermCount
);

  localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH + 1)'(MAX_VALUE);
  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_PC   = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] RST_PC   = WIDTH'(RESET_VALUE);

  if (STEP < 1) begin : g_bad_step
    $error("pc_counter: STEP must be at least 1");
  end
  if (longint'(MAX_VALUE) >= (longint'(1) << WIDTH)) begin : g_bad_max
    $error("pc_counter: MAX_VALUE must fit in WIDTH bits");
  end
  if (RESET_VALUE > MAX_VALUE) begin : g_bad_reset
    $error("pc_counter: RESET_VALUE must not exceed MAX_VALUE");
  end

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] incPc;

  // The extra sum bit keeps the carry so the wrap test sees the true total;
  // a PC at or above MAX_VALUE (possible after an oversized load) restarts at 0.
  always_comb begin
    sum   = {1'b0, PC} + STEP_EXT;
    incPc = sum[WIDTH-1:0];
    if ({1'b0, PC} >= MAX_EXT) begin
      incPc = '0;
    end else if (sum > MAX_EXT) begin
      incPc = WIDTH'(sum - MAX_EXT - 1'b1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      PC <= RST_PC;
    end else if (Load) begin
      PC <= LoadValue;
    end else if (PcEnable) begin
      PC <= incPc;
    end
  end

  assign TermCount = (PC == MAX_PC);

endmodule

// File: tb/tb_pc_counter.sv
// Self-checking bench for pc_counter: directed sequences plus random traffic
// on a default instance and a MAX_VALUE=5/STEP=2 instance sharing the inputs.
module tb_pc_counter;
  import pc_pkg::*;

  localparam int MAX_A  = 511;
  localparam int STEP_A = 1;
  localparam int MAX_B  = 5;
  localparam int STEP_B = 2;

  logic Clock;
  logic Reset;
  logic PcEnable;
  logic Load;
  pc_t  LoadValue;
  pc_t  pcA;
  pc_t  pcB;
  logic termA;
  logic termB;

  int checks;
  int failures;
  int modelA;
  int modelB;

  pc_counter dutA (
    .Clock(Clock), .Reset(Reset), .PcEnable(PcEnable), .Load(Load),
    .LoadValue(LoadValue), .PC(pcA), .TermCount(termA)
  );

  pc_counter #(.MAX_VALUE(MAX_B), .STEP(STEP_B)) dutB (
    .Clock(Clock), .Reset(Reset), .PcEnable(PcEnable), .Load(Load),
    .LoadValue(LoadValue), .PC(pcB), .TermCount(termB)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference rule: reset, then load, then increment with wrap to zero.
  function automatic int refNext(int pc, int maxV, int step, bit rst, bit ld,
                                 bit en, int lv);
    int s;
    if (rst) return 0;
    if (ld) return lv % 512;
    if (!en) return pc;
    if (pc >= maxV) return 0;
    s = pc + step;
    return (s > maxV) ? s - (maxV + 1) : s;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit en, input bit ld, input int lv);
    Reset     = rst;
    PcEnable  = en;
    Load      = ld;
    LoadValue = pc_t'(lv);
    @(posedge Clock);
    #1;
    modelA = refNext(modelA, MAX_A, STEP_A, rst, ld, en, lv);
    modelB = refNext(modelB, MAX_B, STEP_B, rst, ld, en, lv);
    checkOutput("pcA", int'(pcA), modelA);
    checkOutput("termA", int'(termA), (modelA == MAX_A) ? 1 : 0);
    checkOutput("pcB", int'(pcB), modelB);
    checkOutput("termB", int'(termB), (modelB == MAX_B) ? 1 : 0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    modelA    = 0;
    modelB    = 0;
    Reset     = 1'b1;
    PcEnable  = 1'b0;
    Load      = 1'b0;
    LoadValue = '0;
    @(negedge Clock);

    $display("[TB] reset with enable and load asserted");
    applyStimulus(1, 1, 1, 300);
    applyStimulus(1, 1, 1, 300);
    checkOutput("resetPc", int'(pcA), 0);

    $display("[TB] count 7 then hold 3");
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 0);
    checkOutput("after7", int'(pcA), 7);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("hold7", int'(pcA), 7);

    $display("[TB] load beats enable, terminal count and wrap");
    applyStimulus(0, 1, 1, 510);
    checkOutput("load510", int'(pcA), 510);
    applyStimulus(0, 1, 0, 0);
    checkOutput("at511", int'(pcA), 511);
    checkOutput("tcHigh", int'(termA), 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("tcHeld", int'(termA), 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("wrap0", int'(pcA), 0);
    checkOutput("tcLow", int'(termA), 0);

    $display("[TB] reset beats load mid-count");
    applyStimulus(0, 0, 1, 100);
    checkOutput("load100", int'(pcA), 100);
    applyStimulus(1, 1, 1, 300);
    checkOutput("resetWins", int'(pcA), 0);

    $display("[TB] step-2 instance from zero");
    applyStimulus(0, 1, 0, 0);
    checkOutput("b2", int'(pcB), 2);
    applyStimulus(0, 1, 0, 0);
    checkOutput("b4", int'(pcB), 4);
    applyStimulus(0, 1, 0, 0);
    checkOutput("b0", int'(pcB), 0);

    $display("[TB] enable toggling 1,0,1,1,0");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("tog1", int'(pcA), 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("tog2", int'(pcA), 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("tog3", int'(pcA), 2);
    applyStimulus(0, 1, 0, 0);
    checkOutput("tog4", int'(pcA), 3);
    applyStimulus(0, 0, 0, 0);
    checkOutput("tog5", int'(pcA), 3);

    $display("[TB] oversized load into the step-2 instance");
    applyStimulus(0, 0, 1, 200);
    checkOutput("bBig", int'(pcB), 200);
    applyStimulus(0, 1, 0, 0);
    checkOutput("bBigWrap", int'(pcB), 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      int lv;
      if ($urandom_range(0, 3) == 0) lv = 505 + $urandom_range(0, 6);
      else lv = $urandom_range(0, 511);
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 9) == 0, lv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
